nibble_inc_seq: RTL

- Multi-cycle increment / two's-complement negate unit for wide FP ALU operands (mantissa rounding increment, significand negation before add/sub).
- Sequences one shared 4-bit carry-lookahead incrementer over the operand, one nibble per cycle, LSB nibble first.
- Terminates early once the carry dies.
- Uses valid/ready handshakes on both sides and sits between the alignment/rounding stages and the result normaliser.

---
 rtl/nibble_inc_seq_pkg.sv | 5 +
 rtl/nibble_inc_seq_if.sv | 22 ++
 rtl/nibble_inc_seq_cla.sv | 21 ++
 rtl/nibble_inc_seq.sv | 106 ++++++++++
 4 files changed

// File: rtl/nibble_inc_seq_pkg.sv
// Shared types and constants for the FP ALU nibble-serial increment/negate unit.
package fpalu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int unsigned NIB_W = 4;
endpackage

// File: rtl/nibble_inc_seq_if.sv
// Operand/result valid-ready bus between rounding stages and the normaliser.
interface nibble_inc_seq_if #(parameter int unsigned WIDTH = 24);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_neg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_neg, out_ready,
    input  in_ready, out_valid, out_data, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_neg, out_ready,
    output in_ready, out_valid, out_data, out_cout, out_ovf
  );
endinterface

// File: rtl/nibble_inc_seq_cla.sv
// 4-bit carry-lookahead incrementer: S = B + CIN, COUT = carry out of bit 3.
module twos_cla (
  input  logic [3:0] B,
  input  logic       CIN,
  output logic [3:0] S,
  output logic       COUT
);
  logic [4:0] c;

  // Each carry is the AND of CIN with all lower bits, so no ripple chain.
  always_comb begin
    c[0] = CIN;
    c[1] = CIN & B[0];
    c[2] = CIN & B[0] & B[1];
    c[3] = CIN & B[0] & B[1] & B[2];
    c[4] = CIN & (&B);
  end

  assign S    = B ^ c[3:0];
  assign COUT = c[4];
endmodule

// File: rtl/nibble_inc_seq.sv
// Multi-cycle increment / two's-complement negate, one nibble per cycle, LSB first,
// stopping as soon as the carry dies.
module nibble_inc_seq
  import fpalu_pkg::*;
#(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  nibble_inc_seq_if.slave  bus,
  output logic             busy
);
  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state, state_nx;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   work_nx;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic               neg_q;
  logic               msb_q;
  logic [NIB_W-1:0]   nib_sel;
  logic [NIB_W-1:0]   nib_sum;
  logic               cla_cout;
  logic               last;
  logic [WIDTH-1:0]   res_data;
  logic               res_cout;
  logic               res_ovf;

  twos_cla u_cla (
    .B    (nib_sel),
    .CIN  (carry),
    .S    (nib_sum),
    .COUT (cla_cout)
  );

  always_comb begin
    nib_sel = work[NIB_W*int'(idx) +: NIB_W];
    work_nx = work;
    work_nx[NIB_W*int'(idx) +: NIB_W] = nib_sum;
    last = !cla_cout || (idx == IDX_W'(NIB - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work     <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      neg_q    <= 1'b0;
      msb_q    <= 1'b0;
      res_data <= '0;
      res_cout <= 1'b0;
      res_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            work  <= bus.in_neg ? ~bus.in_data : bus.in_data;
            carry <= 1'b1;
            idx   <= '0;
            neg_q <= bus.in_neg;
            msb_q <= bus.in_data[WIDTH-1];
          end
        end
        RUN: begin
          work  <= work_nx;
          carry <= cla_cout;
          idx   <= idx + 1'b1;
          // Result registers load only on completion so they hold between operations.
          if (last) begin
            res_data <= work_nx;
            res_cout <= cla_cout;
            res_ovf  <= neg_q & msb_q & work_nx[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = res_data;
  assign bus.out_cout  = res_cout;
  assign bus.out_ovf   = res_ovf;
  assign busy          = (state != IDLE);
endmodule
